// File: rtl/demultiplexer_1_2_if.sv
// Stream bundle for the 1:2 demux: one shared input stream, two output streams,
// and the per-port delivered-packet counters.
interface demultiplexer_1_2_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;

  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  // Environment side: producer plus both consumers.
  modport master (
    output in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last,
    input  out1_valid, out1_data, out1_last, pkt_cnt0, pkt_cnt1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last,
    output out1_valid, out1_data, out1_last, pkt_cnt0, pkt_cnt1
  );
endinterface

// File: rtl/demultiplexer_1_2.sv
// Streaming 1:2 packet demux; route chosen on first beat and held until last beat.
// Latency 1 cycle per port slot; in_ready follows only the current target port.
module demultiplexer_1_2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  demultiplexer_1_2_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t                    state_q;
  logic                      lock_sel_q;

  logic [1:0]                vld_q,  vld_d;
  logic [1:0]                last_q, last_d;
  logic [1:0][WIDTH-1:0]     dat_q,  dat_d;
  logic [1:0][CNT_W-1:0]     cnt_q,  cnt_d;

  logic [1:0]                out_rdy;
  logic [1:0]                fill;
  logic [1:0]                drain;
  logic                      tgt;
  logic                      in_rdy;
  logic                      in_fire;

  assign out_rdy = {bus.out1_ready, bus.out0_ready};

  // in_sel only matters at a packet boundary; mid-packet the latched port wins.
  assign tgt     = (state_q == ST_LOCKED) ? lock_sel_q : bus.in_sel;
  assign in_rdy  = !rst && (!vld_q[tgt] || out_rdy[tgt]);
  assign in_fire = bus.in_valid && in_rdy;

  always_comb begin
    fill   = '0;
    drain  = '0;
    vld_d  = vld_q;
    last_d = last_q;
    dat_d  = dat_q;
    cnt_d  = cnt_q;
    for (int p = 0; p < 2; p++) begin
      fill[p]  = in_fire && (tgt == 1'(p));
      drain[p] = vld_q[p] && out_rdy[p];
      // A fill wins over a drain so back-to-back beats keep valid high.
      if (fill[p]) begin
        vld_d[p]  = 1'b1;
        dat_d[p]  = bus.in_data;
        last_d[p] = bus.in_last;
      end else if (drain[p]) begin
        vld_d[p]  = 1'b0;
      end
      if (drain[p] && last_q[p]) begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 1'b0;
    end else if (in_fire) begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.in_last) begin
            state_q    <= ST_LOCKED;
            lock_sel_q <= bus.in_sel;
          end
        end
        ST_LOCKED: begin
          if (bus.in_last) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
      dat_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      dat_q  <= dat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out0_valid = vld_q[0];
  assign bus.out0_data  = dat_q[0];
  assign bus.out0_last  = last_q[0];
  assign bus.out1_valid = vld_q[1];
  assign bus.out1_data  = dat_q[1];
  assign bus.out1_last  = last_q[1];
  assign bus.pkt_cnt0   = cnt_q[0];
  assign bus.pkt_cnt1   = cnt_q[1];

endmodule

// File: tb/tb_demultiplexer_1_2.sv
// Directed bench for the 1:2 demux, built with 2-bit counters to reach the wrap.
module tb_demultiplexer_1_2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  demultiplexer_1_2_if #(.WIDTH(8), .CNT_W(2)) bus ();

  demultiplexer_1_2 #(.WIDTH(8), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic sel, input logic last);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = sel;
    bus.in_last  = last;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset held for two edges with in_valid high
    @(negedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out0_valid", bus.out0_valid, 0);
    chk("rst_out1_valid", bus.out1_valid, 0);
    chk("rst_cnt0", bus.pkt_cnt0, 0);
    chk("rst_cnt1", bus.pkt_cnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'hA5, 1'b1, 1'b1); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single-beat routing
    @(negedge clk);
    drive(1'b1, 8'h3C, 1'b0, 1'b1); #1;
    chk("sb_out1_valid", bus.out1_valid, 1);
    chk("sb_out1_data", bus.out1_data, 8'hA5);
    chk("sb_out1_last", bus.out1_last, 1);
    chk("sb_out0_idle", bus.out0_valid, 0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("sb_out0_valid", bus.out0_valid, 1);
    chk("sb_out0_data", bus.out0_data, 8'h3C);
    chk("sb_out1_drained", bus.out1_valid, 0);
    chk("sb_cnt1", bus.pkt_cnt1, 1);
    @(negedge clk); #1;
    chk("sb_cnt0", bus.pkt_cnt0, 1);
    chk("sb_out0_drained", bus.out0_valid, 0);

    // Select lock: sel flips to 1 mid-packet but beats stay on port 0
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h22, 1'b1, 1'b0); #1;
    chk("lk_b0_data", bus.out0_data, 8'h11);
    @(negedge clk);
    drive(1'b1, 8'h33, 1'b1, 1'b1); #1;
    chk("lk_b1_data", bus.out0_data, 8'h22);
    chk("lk_b1_out1", bus.out1_valid, 0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("lk_b2_data", bus.out0_data, 8'h33);
    chk("lk_b2_last", bus.out0_last, 1);
    chk("lk_b2_out1", bus.out1_valid, 0);
    @(negedge clk); #1;
    chk("lk_cnt0", bus.pkt_cnt0, 2);
    chk("lk_cnt1", bus.pkt_cnt1, 1);

    // Backpressure isolation
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'h44, 1'b0, 1'b1); #1;
    chk("bp_first_rdy", bus.in_ready, 1);
    @(negedge clk);
    drive(1'b1, 8'h55, 1'b0, 1'b1); #1;
    chk("bp_blocked_rdy", bus.in_ready, 0);
    chk("bp_out0_data", bus.out0_data, 8'h44);
    @(negedge clk);
    drive(1'b1, 8'h77, 1'b1, 1'b1); #1;
    chk("bp_port1_rdy", bus.in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("bp_out1_data", bus.out1_data, 8'h77);
    chk("bp_out0_hold_v", bus.out0_valid, 1);
    chk("bp_out0_hold_d", bus.out0_data, 8'h44);
    @(negedge clk); #1;
    chk("bp_cnt1", bus.pkt_cnt1, 2);
    chk("bp_out1_drained", bus.out1_valid, 0);
    chk("bp_out0_still", bus.out0_data, 8'h44);
    bus.out0_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_cnt0", bus.pkt_cnt0, 3);

    // Throughput: 8-beat packet to port 1, drain+fill each cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), (i == 0) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0); #1;
      chk("tp_in_ready", bus.in_ready, 1);
      if (i > 0) begin
        chk("tp_out1_valid", bus.out1_valid, 1);
        chk("tp_out1_data", bus.out1_data, i - 1);
        chk("tp_out0_idle", bus.out0_valid, 0);
      end
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("tp_last_valid", bus.out1_valid, 1);
    chk("tp_last_data", bus.out1_data, 8'h07);
    chk("tp_last_flag", bus.out1_last, 1);
    @(negedge clk); #1;
    chk("tp_cnt1", bus.pkt_cnt1, 3);

    // Counter wrap on port 0 from a clean reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("wr_cnt0_zero", bus.pkt_cnt0, 0);
    chk("wr_cnt1_zero", bus.pkt_cnt1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h80 + k), 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("wr_cnt0", bus.pkt_cnt0, wrap_exp[k]);
    end

    // Mid-packet reset discards the open packet and its lock
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'hB2, 1'b0, 1'b1); #1;
    chk("mr_in_ready", bus.in_ready, 0);
    chk("mr_buffered", bus.out0_valid, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.out0_ready = 1'b1;
    drive(1'b1, 8'hC3, 1'b1, 1'b1); #1;
    chk("mr_out0_empty", bus.out0_valid, 0);
    chk("mr_out1_empty", bus.out1_valid, 0);
    chk("mr_cnt0", bus.pkt_cnt0, 0);
    chk("mr_cnt1", bus.pkt_cnt1, 0);
    chk("mr_in_ready_rel", bus.in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("mr_route_valid", bus.out1_valid, 1);
    chk("mr_route_data", bus.out1_data, 8'hC3);
    chk("mr_route_out0", bus.out0_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
